hack_cpu_sequencer: RTL and testbench

- Multi-cycle Hack-style control unit: fetches 16-bit instructions, decodes them and drives the six ALU control bits plus both ALU operands.
- Consumes the ALU result and its zr/ng flags for register writeback and jump decisions.
- Owns the A, D and PC registers and sequences instruction-memory and data-memory handshakes.
- Sits between instruction/data memories and the combinational 16-bit ALU.

---
 rtl/hack_cpu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_hack_cpu_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_sequencer.sv
// Multi-cycle Hack control unit: owns A, D and PC, fetches and decodes
// instructions, drives an external combinational ALU and sequences the
// instruction/data memory handshakes one transfer at a time.
module hack_cpu_sequencer #(
    parameter int                ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_wdata,
    input  logic [15:0]       dmem_rdata,
    input  logic              dmem_valid,
    output logic [15:0]       alu_x,
    output logic [15:0]       alu_y,
    output logic              alu_zx,
    output logic              alu_nx,
    output logic              alu_zy,
    output logic              alu_ny,
    output logic              alu_f,
    output logic              alu_no,
    input  logic [15:0]       alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [ADDR_W-1:0] pc_o,
    output logic [15:0]       a_o,
    output logic [15:0]       d_o,
    output logic              retire
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEMRD,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [15:0]       a_reg, a_next;
    logic [15:0]       d_reg, d_next;
    logic [15:0]       ir_reg, ir_next;
    logic [15:0]       mdr_reg, mdr_next;
    logic [15:0]       res_reg, res_next;
    logic              jmp_reg, jmp_next;
    // Set once the M write of the current instruction has completed, so the
    // commit happens on the following edge rather than the completion edge.
    logic              wr_done_reg, wr_done_next;
    logic [ADDR_W-1:0] pc_plus1;

    assign pc_plus1   = pc_reg + PC_ONE;

    assign imem_addr  = pc_reg;
    assign dmem_addr  = a_reg[ADDR_W-1:0];
    assign dmem_wdata = res_reg;
    assign alu_x      = d_reg;
    assign alu_y      = ir_reg[12] ? mdr_reg : a_reg;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_reg[11:6];
    assign pc_o       = pc_reg;
    assign a_o        = a_reg;
    assign d_o        = d_reg;

    // State and architectural registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_FETCH;
            pc_reg      <= RESET_PC;
            a_reg       <= '0;
            d_reg       <= '0;
            ir_reg      <= '0;
            mdr_reg     <= '0;
            res_reg     <= '0;
            jmp_reg     <= 1'b0;
            wr_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            a_reg       <= a_next;
            d_reg       <= d_next;
            ir_reg      <= ir_next;
            mdr_reg     <= mdr_next;
            res_reg     <= res_next;
            jmp_reg     <= jmp_next;
            wr_done_reg <= wr_done_next;
        end
    end

    // Next-state, register updates and handshake outputs.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        a_next       = a_reg;
        d_next       = d_reg;
        ir_next      = ir_reg;
        mdr_next     = mdr_reg;
        res_next     = res_reg;
        jmp_next     = jmp_reg;
        wr_done_next = wr_done_reg;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        retire       = 1'b0;

        case (state_reg)
            S_FETCH: begin
                // Gated by reset_n so a pending fetch is dropped the moment
                // reset asserts, not at the next clock edge.
                imem_req = reset_n;
                if (imem_valid) begin
                    ir_next    = imem_rdata;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!ir_reg[15]) begin
                    a_next     = {1'b0, ir_reg[14:0]};
                    pc_next    = pc_plus1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (ir_reg[12]) begin
                    state_next = S_MEMRD;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_MEMRD: begin
                dmem_req = 1'b1;
                if (dmem_valid) begin
                    mdr_next   = dmem_rdata;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                res_next   = alu_out;
                jmp_next   = (ir_reg[2] & alu_ng) | (ir_reg[1] & alu_zr) |
                             (ir_reg[0] & ~alu_ng & ~alu_zr);
                state_next = S_WB;
            end
            S_WB: begin
                if (ir_reg[3] && !wr_done_reg) begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                    if (dmem_valid) begin
                        wr_done_next = 1'b1;
                    end
                end else begin
                    // Jump target and M address come from the old A, which is
                    // only overwritten on this same edge.
                    if (ir_reg[5]) begin
                        a_next = res_reg;
                    end
                    if (ir_reg[4]) begin
                        d_next = res_reg;
                    end
                    pc_next      = jmp_reg ? a_reg[ADDR_W-1:0] : pc_plus1;
                    wr_done_next = 1'b0;
                    retire       = 1'b1;
                    state_next   = S_FETCH;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_hack_cpu_sequencer.sv
// Scoreboard bench for hack_cpu_sequencer: an instruction-level Hack model
// queues expected fetches, data transfers and retire results; a monitor
// compares them against what the DUT presents.
module tb_hack_cpu_sequencer;

    localparam logic [14:0] RESET_PC = 15'd0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req, imem_valid;
    logic [14:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_valid;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata, dmem_rdata;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
    logic [14:0] pc_o;
    logic [15:0] a_o, d_o;
    logic        retire;

    hack_cpu_sequencer #(.ADDR_W(15), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
        .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out), .alu_zr(alu_zr),
        .alu_ng(alu_ng), .pc_o(pc_o), .a_o(a_o), .d_o(d_o), .retire(retire)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Standard Hack ALU, used both as the external ALU and by the model.
    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];

    logic [15:0] imem    [0:32767];
    logic [15:0] env_ram [0:32767];
    logic [15:0] ref_ram [0:32767];

    typedef struct {
        logic [14:0] pc;
        logic [15:0] a;
        logic [15:0] d;
        bit          is_c;
        logic [5:0]  ctrl;
        logic [15:0] x;
        logic [15:0] y;
        int          lat;
    } ret_t;

    typedef struct {
        bit          we;
        logic [14:0] addr;
        logic [15:0] wdata;
    } dm_t;

    ret_t        exp_retire[$];
    dm_t         exp_dmem[$];
    logic [14:0] exp_fetch[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // ---------------- memory responders ----------------
    int  fetch_budget = 0;
    int  i_fix = 0, d_fix = 0, max_wait = 0;
    bit  zero_wait = 1'b1;
    int  i_grants, i_cnt, i_target, d_cnt, d_target;
    bit          d_we_l;
    logic [14:0] d_addr_l;
    logic [15:0] d_wdata_l;

    function automatic int pick(input int fix);
        if (fix >= 0) return fix;
        return int'($urandom_range(0, max_wait));
    endfunction

    initial begin
        imem_valid = 1'b0; imem_rdata = 16'h0; dmem_valid = 1'b0; dmem_rdata = 16'h0;
        i_grants = 0; i_cnt = 0; i_target = 0; d_cnt = 0; d_target = 0;
        d_we_l = 1'b0; d_addr_l = 15'h0; d_wdata_l = 16'h0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                imem_valid = 1'b0; dmem_valid = 1'b0;
                i_grants = 0; i_cnt = 0; i_target = pick(i_fix);
                d_cnt = 0; d_target = pick(d_fix);
            end else begin
                if (imem_valid) begin
                    imem_valid = 1'b0; i_cnt = 0; i_target = pick(i_fix);
                end else if (imem_req && i_grants < fetch_budget) begin
                    if (i_cnt >= i_target) begin
                        imem_valid = 1'b1; imem_rdata = imem[imem_addr]; i_grants++;
                    end else begin
                        i_cnt++;
                    end
                end
                if (dmem_valid) begin
                    dmem_valid = 1'b0;
                    if (d_we_l) env_ram[d_addr_l] = d_wdata_l;
                    d_cnt = 0; d_target = pick(d_fix);
                end else if (dmem_req) begin
                    if (d_cnt >= d_target) begin
                        dmem_valid = 1'b1;
                        d_we_l = dmem_we; d_addr_l = dmem_addr; d_wdata_l = dmem_wdata;
                        dmem_rdata = dmem_we ? 16'($urandom) : env_ram[dmem_addr];
                    end else begin
                        d_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- reference model (one instruction per call) ----------------
    logic [14:0] r_pc;
    logic [15:0] r_a, r_d;

    task automatic ref_exec();
        logic [15:0] ins, y, o;
        logic [14:0] old_a;
        bit          jmp;
        ret_t        r;
        dm_t         t;
        ins = imem[r_pc];
        exp_fetch.push_back(r_pc);
        r.is_c = ins[15]; r.ctrl = ins[11:6]; r.x = r_d; r.y = 16'h0;
        if (!ins[15]) begin
            r_a   = {1'b0, ins[14:0]};
            r_pc  = r_pc + 15'd1;
            r.lat = 2;
        end else begin
            old_a = r_a[14:0];
            r.lat = 4;
            if (ins[12]) begin
                t.we = 1'b0; t.addr = old_a; t.wdata = 16'h0;
                exp_dmem.push_back(t);
                y = ref_ram[old_a];
                r.lat++;
            end else begin
                y = r_a;
            end
            r.y = y;
            o   = hack_alu(r_d, y, ins[11:6]);
            jmp = (ins[2] && $signed(o) < 0) || (ins[1] && o == 16'h0) || (ins[0] && $signed(o) > 0);
            if (ins[3]) begin
                t.we = 1'b1; t.addr = old_a; t.wdata = o;
                exp_dmem.push_back(t);
                ref_ram[old_a] = o;
                r.lat++;
            end
            if (ins[5]) r_a = o;
            if (ins[4]) r_d = o;
            r_pc = jmp ? old_a : r_pc + 15'd1;
        end
        r.pc = r_pc; r.a = r_a; r.d = r_d;
        exp_retire.push_back(r);
    endtask

    // ---------------- monitor ----------------
    ret_t        cur_exp;
    bit          pend = 1'b0, have_prev = 1'b0;
    int          prev_cyc = 0;
    bit          prev_i = 1'b0, prev_d = 1'b0, prev_dwe = 1'b0;
    logic [14:0] prev_iaddr = 15'h0, prev_daddr = 15'h0;
    logic [15:0] prev_dwd = 16'h0;

    initial begin
        logic [14:0] f;
        dm_t         t;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                pend = 1'b0; have_prev = 1'b0; prev_i = 1'b0; prev_d = 1'b0;
            end else begin
                if (pend) begin
                    check("commit_pc_a_d", 64'({pc_o, a_o, d_o}), 64'({cur_exp.pc, cur_exp.a, cur_exp.d}));
                    pend = 1'b0;
                end
                if (prev_i)
                    check("imem_hold", 64'({imem_req, imem_addr}), 64'({1'b1, prev_iaddr}));
                if (prev_d)
                    check("dmem_hold", 64'({dmem_req, dmem_we, dmem_addr, dmem_wdata}),
                          64'({1'b1, prev_dwe, prev_daddr, prev_dwd}));
                if (imem_req && imem_valid) begin
                    if (exp_fetch.size() == 0) fail("fetch", "unexpected fetch");
                    else begin
                        f = exp_fetch.pop_front();
                        check("fetch_addr", 64'(imem_addr), 64'(f));
                    end
                end
                if (dmem_req && dmem_valid) begin
                    $display("dmem we=%0d addr=%04h wdata=%04h", dmem_we, dmem_addr, dmem_wdata);
                    if (exp_dmem.size() == 0) fail("dmem", "unexpected data transfer");
                    else begin
                        t = exp_dmem.pop_front();
                        check("dmem_xfer", 64'({dmem_we, dmem_addr, dmem_we ? dmem_wdata : 16'h0}),
                              64'({t.we, t.addr, t.wdata}));
                    end
                end
                if (retire) begin
                    if (exp_retire.size() == 0) fail("retire", "unexpected retire");
                    else begin
                        cur_exp = exp_retire.pop_front();
                        pend = 1'b1;
                        $display("retire cyc=%0d -> pc=%04h a=%04h d=%04h", cyc, cur_exp.pc, cur_exp.a, cur_exp.d);
                        if (cur_exp.is_c)
                            check("alu_inputs",
                                  64'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_x, alu_y}),
                                  64'({cur_exp.ctrl, cur_exp.x, cur_exp.y}));
                        if (zero_wait && have_prev)
                            check("latency", 64'(cyc - prev_cyc), 64'(cur_exp.lat));
                    end
                    have_prev = 1'b1;
                    prev_cyc  = cyc;
                end
                prev_i = imem_req && !imem_valid; prev_iaddr = imem_addr;
                prev_d = dmem_req && !dmem_valid; prev_dwe = dmem_we;
                prev_daddr = dmem_addr; prev_dwd = dmem_wdata;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_mem();
        for (int k = 0; k < 32768; k++) begin
            imem[k] = 16'h0; env_ram[k] = 16'h0; ref_ram[k] = 16'h0;
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 9) < 4) w[15] = 1'b0;
        else w[15:13] = 3'b111;
        return w;
    endfunction

    // Reset the DUT, model n instructions, then let it run exactly n fetches.
    task automatic run_prog(input int n, input int ifix, input int dfix, input int mw);
        i_fix = ifix; d_fix = dfix; max_wait = mw;
        zero_wait = (ifix == 0 && dfix == 0);
        @(negedge clk); #3 reset_n = 1'b0;
        fetch_budget = n;
        @(negedge clk);
        @(negedge clk);
        r_pc = RESET_PC; r_a = 16'h0; r_d = 16'h0;
        for (int k = 0; k < n; k++) ref_exec();
        #3 reset_n = 1'b1;
        for (int c = 0; c < 5000 && (exp_retire.size() != 0 || pend); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        check("drained", 64'({exp_retire.size() == 0, exp_fetch.size() == 0, exp_dmem.size() == 0, pend}),
              64'(4'b1110));
        exp_retire.delete(); exp_fetch.delete(); exp_dmem.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        clear_mem();
        repeat (2) @(negedge clk);
        #2;
        check("rst_handshake", 64'({imem_req, dmem_req, dmem_we, retire}), 64'(0));
        check("rst_regs", 64'({pc_o, a_o, d_o}), 64'({RESET_PC, 32'h0}));
        check("rst_alu", 64'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_x, alu_y}), 64'(0));

        // @7; D=A
        clear_mem();
        imem[0] = 16'h0007; imem[1] = 16'hEC10;
        run_prog(2, 0, 0, 0);
        check("t1_final", 64'({pc_o, a_o, d_o}), 64'({15'd2, 16'd7, 16'd7}));

        // @3; D=A; @100; M=D
        clear_mem();
        imem[0] = 16'h0003; imem[1] = 16'hEC10; imem[2] = 16'h0064; imem[3] = 16'hE308;
        run_prog(4, 0, 0, 0);
        check("t2_mem100", 64'(env_ram[100]), 64'(16'd3));

        // @100; D=M with three dmem wait states
        clear_mem();
        env_ram[100] = 16'h8000; ref_ram[100] = 16'h8000;
        imem[0] = 16'h0064; imem[1] = 16'hFC10;
        run_prog(2, 0, 3, 0);
        check("t3_d", 64'(d_o), 64'(16'h8000));

        // @5; D=A; @10; D;JGT -> taken
        clear_mem();
        imem[0] = 16'h0005; imem[1] = 16'hEC10; imem[2] = 16'h000A; imem[3] = 16'hE301;
        run_prog(4, 0, 0, 0);
        check("t4_jgt_taken", 64'(pc_o), 64'(15'd10));

        // @0; D=A; @10; D;JGT -> falls through to the word after the jump
        clear_mem();
        imem[0] = 16'h0000; imem[1] = 16'hEC10; imem[2] = 16'h000A; imem[3] = 16'hE301;
        run_prog(4, 0, 0, 0);
        check("t5_jgt_fall", 64'(pc_o), 64'(15'd4));

        // @0x7FFF; 0;JMP; then an A-instruction at 0x7FFF wraps PC to 0
        clear_mem();
        imem[0] = 16'h7FFF; imem[1] = 16'hEA87; imem[15'h7FFF] = 16'h0001;
        run_prog(2, 0, 0, 0);
        check("t6_jmp_top", 64'(pc_o), 64'(15'h7FFF));
        run_prog(3, 0, 0, 0);
        check("t7_pc_wrap", 64'({pc_o, a_o}), 64'({15'h0000, 16'h0001}));

        // Random programs, random memory contents and wait states
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < 32768; k++) begin
                imem[k] = rand_instr();
                env_ram[k] = 16'($urandom);
                ref_ram[k] = env_ram[k];
            end
            if (r == 0) run_prog(40, 0, 0, 0);
            else        run_prog(40, -1, -1, 3);
        end

        // Reset while a fetch is being withheld
        imem[0] = 16'h1234; imem[1] = 16'h0042;
        run_prog(2, 0, 0, 0);
        check("t8_pre_reset", 64'({imem_req, imem_addr, a_o}), 64'({1'b1, 15'd2, 16'h0042}));
        fetch_budget = 0;
        @(negedge clk); #2 reset_n = 1'b0;
        #1;
        check("t8_in_reset", 64'({imem_req, pc_o, a_o, d_o}), 64'({1'b0, RESET_PC, 32'h0}));
        @(negedge clk); #2 reset_n = 1'b1;
        @(negedge clk); #2;
        check("t8_refetch", 64'({imem_req, imem_addr}), 64'({1'b1, RESET_PC}));
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
